// File: rtl/matmul_engine.sv
// rtl/matmul_engine.sv - N x N matrix-multiply engine built around one time-shared MAC
//
// Purpose:
//   Streams in W then X (row-major, N*N elements each), computes C = W * X
//   with a single multiply-accumulate unit (i outer, j middle, k inner, one
//   MAC per cycle), then streams C out row-major over a valid/ready port.
//   Sequenced by an IDLE -> LOAD -> COMPUTE -> UNLOAD -> IDLE state machine.
//
// Optional feature macro: MATMUL_ACC_EN
//   Defined   : start with i_acc=1 seeds every accumulator from the stored
//               C[i][j], giving C = C_prev + W * X (wraps modulo 2^OW).
//   Undefined : i_acc is ignored and every accumulator starts from zero.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_start      one-cycle job request, sampled only in IDLE
//   i_acc        accumulate request, sampled with i_start (MATMUL_ACC_EN only)
//   i_in_valid   i_data_in is valid
//   o_in_ready   engine accepts i_data_in (high throughout LOAD)
//   i_data_in    DW-bit unsigned element stream (W then X)
//   o_out_valid  o_data_out is valid (high throughout UNLOAD)
//   i_out_ready  sink accepts o_data_out
//   o_data_out   OW-bit result element, zero outside UNLOAD
//   o_busy       high in every state but IDLE, and in the done cycle
//   o_done       one-cycle pulse after the final output handshake
module matmul_engine #(
  parameter int N  = 3,
  parameter int DW = 4,
  parameter int OW = 2*DW + $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_acc,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [DW-1:0] i_data_in,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [OW-1:0] o_data_out,
  output logic          o_busy,
  output logic          o_done
);

  localparam int NN = N * N;
  localparam int AW = $clog2(NN);
  localparam int LW = $clog2(2 * NN);
  localparam int IW = $clog2(N);

  localparam logic [LW-1:0] LD_LAST  = LW'(2 * NN - 1);
  localparam logic [LW-1:0] LD_W_END = LW'(NN);
  localparam logic [AW-1:0] OUT_LAST = AW'(NN - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_UNLOAD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DW-1:0] r_w [NN];
  logic [DW-1:0] r_x [NN];
  logic [OW-1:0] r_c [NN];

  logic [LW-1:0] r_ld_cnt;
  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;
  logic [IW-1:0] r_k;
  logic [AW-1:0] r_out_cnt;
  logic [OW-1:0] r_acc;
  logic          r_done;

  logic            w_load_hs;
  logic            w_out_hs;
  logic            w_load_last;
  logic            w_mac_last;
  logic            w_unload_last;
  logic [AW-1:0]   w_w_idx;
  logic [AW-1:0]   w_x_idx;
  logic [AW-1:0]   w_c_idx;
  logic [2*DW-1:0] w_prod;
  logic [OW-1:0]   w_seed;
  logic [OW-1:0]   w_sum;

`ifdef MATMUL_ACC_EN
  logic r_acc_mode;
`else
  logic w_unused_acc;
  assign w_unused_acc = i_acc;
`endif

  assign w_load_hs     = (r_state == S_LOAD) && i_in_valid;
  assign w_out_hs      = (r_state == S_UNLOAD) && i_out_ready;
  assign w_load_last   = (r_ld_cnt == LD_LAST);
  assign w_unload_last = (r_out_cnt == OUT_LAST);
  assign w_mac_last    = (r_state == S_COMPUTE) && (r_i == IDX_LAST) &&
                         (r_j == IDX_LAST) && (r_k == IDX_LAST);

  // Flat row-major addresses of W[i][k], X[k][j] and C[i][j].
  assign w_w_idx = AW'(int'(r_i) * N + int'(r_k));
  assign w_x_idx = AW'(int'(r_k) * N + int'(r_j));
  assign w_c_idx = AW'(int'(r_i) * N + int'(r_j));

  assign w_prod = (2*DW)'(r_w[w_w_idx]) * (2*DW)'(r_x[w_x_idx]);

`ifdef MATMUL_ACC_EN
  assign w_seed = r_acc_mode ? r_c[w_c_idx] : '0;
`else
  assign w_seed = '0;
`endif

  // k == 0 starts a new dot product from the seed instead of the running sum.
  assign w_sum = ((r_k == '0) ? w_seed : r_acc) + OW'(w_prod);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_data_out  = '0;
    o_busy      = r_done;
    o_done      = r_done;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
        if (w_load_hs && w_load_last) begin
          w_state_nxt = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        o_busy = 1'b1;
        if (w_mac_last) begin
          w_state_nxt = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        o_data_out  = r_c[r_out_cnt];
        if (w_out_hs && w_unload_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Counters and sequencing registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ld_cnt  <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_out_cnt <= '0;
      r_acc     <= '0;
      r_done    <= 1'b0;
`ifdef MATMUL_ACC_EN
      r_acc_mode <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;

`ifdef MATMUL_ACC_EN
      if ((r_state == S_IDLE) && i_start) begin
        r_acc_mode <= i_acc;
      end
`endif

      if (w_load_hs) begin
        r_ld_cnt <= w_load_last ? '0 : r_ld_cnt + LW'(1);
      end

      if (r_state == S_COMPUTE) begin
        r_acc <= w_sum;
        if (r_k == IDX_LAST) begin
          r_k <= '0;
          if (r_j == IDX_LAST) begin
            r_j <= '0;
            r_i <= (r_i == IDX_LAST) ? '0 : r_i + IW'(1);
          end else begin
            r_j <= r_j + IW'(1);
          end
        end else begin
          r_k <= r_k + IW'(1);
        end
      end

      if (w_out_hs) begin
        r_out_cnt <= w_unload_last ? '0 : r_out_cnt + AW'(1);
        if (w_unload_last) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  // Matrix storage carries no reset: every job reloads W and X, and C is
  // fully rewritten before UNLOAD can present it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (w_load_hs) begin
        if (r_ld_cnt < LD_W_END) begin
          r_w[AW'(r_ld_cnt)] <= i_data_in;
        end else begin
          r_x[AW'(r_ld_cnt - LD_W_END)] <= i_data_in;
        end
      end
      if ((r_state == S_COMPUTE) && (r_k == IDX_LAST)) begin
        r_c[w_c_idx] <= w_sum;
      end
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
// tb/tb_matmul_engine.sv - self-checking bench for matmul_engine
`timescale 1ns/1ps
module tb_matmul_engine;

  localparam int N  = 3;
  localparam int DW = 4;
  localparam int OW = 10;
  localparam int NN = N * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          acc;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] data_out;
  logic          busy;
  logic          done;

  matmul_engine #(.N(N), .DW(DW), .OW(OW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_acc       (acc),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_data_in   (data_in),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_data_out  (data_out),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  int g_w [NN];
  int g_x [NN];
  int g_exp [NN];
  int got [NN];
  int model_c [NN];
  int first_cyc;
  int done_cyc;
  int c0;

  typedef struct {
    int w [NN];
    int x [NN];
    bit gaps;
    bit sp_load;
    bit sp_unload;
    int stall_beat;
    int stall_len;
    int exp [NN];
    int exp_first;
    int exp_done;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // C = (acc ? C_prev : 0) + W * X, modulo 2^OW, from the textbook definition.
  task automatic model(input bit use_acc);
    int s;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = use_acc ? model_c[i*N+j] : 0;
        for (int k = 0; k < N; k++) s += g_w[i*N+k] * g_x[k*N+j];
        g_exp[i*N+j] = s % (1 << OW);
      end
    end
    for (int e = 0; e < NN; e++) model_c[e] = g_exp[e];
  endtask

  task automatic load_phase(input bit a, input bit gaps, input bit sp);
    int idx;
    int guard;
    bit rdy;
    bit gap;
    start = 1'b1;
    acc   = a;
    c0    = cyc;
    @(negedge clk);
    start = 1'b0;
    acc   = 1'b0;
    idx   = 0;
    guard = 0;
    while (idx < 2*NN && guard < 1000) begin
      rdy      = in_ready;
      gap      = gaps && ($urandom_range(2) == 0);
      in_valid = !gap;
      data_in  = DW'((idx < NN) ? g_w[idx] : g_x[idx-NN]);
      start    = sp && (idx == 5);
      @(negedge clk);
      guard++;
      if (rdy && !gap) idx++;
    end
    start = 1'b0;
    // Junk left on the bus for one more cycle must not be taken.
    in_valid = 1'b1;
    data_in  = '1;
    check("load_count", idx, 2*NN);
    check("in_ready_drop", int'(in_ready), 0);
  endtask

  task automatic unload_phase(input int stall_beat, input int stall_len, input bit sp);
    int guard;
    int beats;
    int left;
    bit stall;
    bit v;
    int d;
    guard = 0;
    while (!out_valid && guard < 500) begin
      @(negedge clk);
      in_valid = 1'b0;
      guard++;
    end
    in_valid  = 1'b0;
    first_cyc = cyc - c0;
    check("first_valid_seen", int'(out_valid), 1);
    beats = 0;
    left  = stall_len;
    guard = 0;
    while (beats < NN && guard < 500) begin
      stall = (beats == stall_beat) && (left > 0);
      if (stall) left--;
      out_ready = !stall;
      v     = out_valid;
      d     = int'(data_out);
      start = sp && (beats == 4);
      @(negedge clk);
      guard++;
      if (v && !stall) begin
        got[beats] = d;
        beats++;
      end else if (v) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(data_out), d);
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    done_cyc  = cyc - c0;
    check("unload_beats", beats, NN);
    check("done_pulse", int'(done), 1);
    check("busy_in_done", int'(busy), 1);
    check("valid_after_last", int'(out_valid), 0);
    @(negedge clk);
    check("done_low", int'(done), 0);
    check("busy_low", int'(busy), 0);
  endtask

  task automatic run_job(input bit a, input bit gaps, input bit spl, input int sb,
                         input int sl, input bit spu);
    load_phase(a, gaps, spl);
    unload_phase(sb, sl, spu);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_data_out"}, int'(data_out), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    acc       = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Hand-written vectors.
    for (int t = 0; t < 5; t++) begin
      for (int e = 0; e < NN; e++) begin
        tbl[t].w[e] = 0;
        tbl[t].x[e] = e + 1;
      end
      tbl[t].gaps = 0; tbl[t].sp_load = 0; tbl[t].sp_unload = 0;
      tbl[t].stall_beat = -1; tbl[t].stall_len = 0;
      tbl[t].exp_first = 46; tbl[t].exp_done = 55;
    end
    // 0: identity * [1..9]
    tbl[0].w = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    tbl[0].exp = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    // 1: all fifteens, largest possible sum without overflow
    tbl[1].w = '{15, 15, 15, 15, 15, 15, 15, 15, 15};
    tbl[1].x = '{15, 15, 15, 15, 15, 15, 15, 15, 15};
    tbl[1].exp = '{675, 675, 675, 675, 675, 675, 675, 675, 675};
    // 2: backpressure for 5 cycles on the beat carrying 3
    tbl[2].w = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    tbl[2].stall_beat = 2; tbl[2].stall_len = 5;
    tbl[2].exp = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    tbl[2].exp_done = 60;
    // 3: 2*identity with start pulsed during LOAD and UNLOAD
    tbl[3].w = '{2, 0, 0, 0, 2, 0, 0, 0, 2};
    tbl[3].sp_load = 1; tbl[3].sp_unload = 1;
    tbl[3].exp = '{2, 4, 6, 8, 10, 12, 14, 16, 18};
    // 4: all-ones W gives column sums of X; input stream has gaps
    tbl[4].w = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    tbl[4].gaps = 1;
    tbl[4].exp = '{12, 15, 18, 12, 15, 18, 12, 15, 18};
    tbl[4].exp_first = -1; tbl[4].exp_done = -1;

    for (int t = 0; t < 5; t++) begin
      for (int e = 0; e < NN; e++) begin
        g_w[e] = tbl[t].w[e];
        g_x[e] = tbl[t].x[e];
      end
      run_job(1'b0, tbl[t].gaps, tbl[t].sp_load, tbl[t].stall_beat, tbl[t].stall_len,
              tbl[t].sp_unload);
      for (int e = 0; e < NN; e++) check($sformatf("vec%0d_c%0d", t, e), got[e], tbl[t].exp[e]);
      if (tbl[t].exp_first >= 0) check($sformatf("vec%0d_first", t), first_cyc, tbl[t].exp_first);
      if (tbl[t].exp_done >= 0) check($sformatf("vec%0d_done", t), done_cyc, tbl[t].exp_done);
      // Idle after the job: start pulses must not have spawned another one.
      check_idle_outputs($sformatf("vec%0d_idle", t));
    end

    // Randomized jobs against the reference model.
    for (int r = 0; r < 8; r++) begin
      for (int e = 0; e < NN; e++) begin
        g_w[e] = int'($urandom_range(15));
        g_x[e] = int'($urandom_range(15));
      end
      model(1'b0);
      run_job(1'b0, 1'($urandom_range(1)), 1'b0, int'($urandom_range(8)),
              int'($urandom_range(4)), 1'($urandom_range(1)));
      for (int e = 0; e < NN; e++) check($sformatf("rand%0d_c%0d", r, e), got[e], g_exp[e]);
    end

    // Accumulate: second all-fifteens job with acc=1.
    for (int e = 0; e < NN; e++) begin
      g_w[e] = 15;
      g_x[e] = 15;
    end
    run_job(1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
    for (int e = 0; e < NN; e++) check($sformatf("acc_first_c%0d", e), got[e], 675);
    run_job(1'b1, 1'b0, 1'b0, -1, 0, 1'b0);
`ifdef MATMUL_ACC_EN
    for (int e = 0; e < NN; e++) check($sformatf("acc_second_c%0d", e), got[e], 326);
`else
    for (int e = 0; e < NN; e++) check($sformatf("acc_ignored_c%0d", e), got[e], 675);
`endif

    // Reset in the middle of COMPUTE, then a fresh job.
    for (int e = 0; e < NN; e++) begin
      g_w[e] = int'($urandom_range(15));
      g_x[e] = int'($urandom_range(15));
    end
    load_phase(1'b0, 1'b0, 1'b0);
    begin
      int guard;
      guard = 0;
      while ((cyc - c0) < 30 && guard < 100) begin
        @(negedge clk);
        in_valid = 1'b0;
        guard++;
      end
    end
    check("midjob_cycle", cyc - c0, 30);
    check("midjob_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    for (int e = 0; e < NN; e++) begin
      g_w[e] = int'($urandom_range(15));
      g_x[e] = int'($urandom_range(15));
    end
    model(1'b0);
    run_job(1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
    for (int e = 0; e < NN; e++) check($sformatf("post_rst_c%0d", e), got[e], g_exp[e]);
    check("post_rst_first", first_cyc, 46);
    check("post_rst_done", done_cyc, 55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised N×N matrix-multiply engine, the next-generation replacement for the fixed 3×3 memory-bank-plus-multiplier datapath. It streams in a weight matrix W and an input matrix X over a single valid/ready port, computes C = W·X with one time-shared multiply-accumulate unit, and streams C out over a valid/ready port. It sits between the host-side loader and the result sink, and is sequenced internally by an FSM instead of external row/column select lines.

## Interface
- N, default 3: matrix dimension (N ≥ 2).
- DW, default 4: unsigned element width of W and X.
- OW, default 2*DW+$clog2(N): result width, 10 at the default N and DW.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a job; sampled only in IDLE.
- acc  in  1  accumulate request, sampled together with start. Used only when MATMUL_ACC_EN is defined.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  engine accepts data_in.
- data_in  in  DW  element stream.
- out_valid  out  1  data_out is valid.
- out_ready  in  1  sink accepts data_out.
- data_out  out  OW  result element.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final output handshake.

## Operation
- FSM states: IDLE → LOAD → COMPUTE → UNLOAD → IDLE.
- **IDLE**
  - start=1 moves the FSM to LOAD on the next cycle.
  - start is ignored in all other states.
- **LOAD**
  - in_ready=1.
  - Each in_valid&&in_ready cycle writes one element.
  - The first N² elements go to W, in row-major order; the next N² go to X, in row-major order.
  - Gaps in in_valid are allowed.
  - After the 2N²-th accepted element, the FSM moves to COMPUTE.
- **COMPUTE**
  - One MAC per cycle, i outer, j middle, k inner.
  - C[i][j] = Σk W[i][k]·X[k][j].
  - The accumulator clears at k=0 (see Configuration). C[i][j] is written when k=N-1.
  - Total duration: exactly N³ cycles.
  - Products are DW×DW → 2DW bits. The sum is OW bits; it cannot overflow when accumulate is disabled.
- **UNLOAD**
  - C is presented in row-major order, N² beats.
  - data_out is held stable while out_valid && !out_ready.
  - After the last handshake: done=1 for one cycle, then the FSM is in IDLE.
- W and X buffers persist across jobs; every job reloads them.

## Timing
- Reset values: FSM=IDLE, in_ready=0, out_valid=0, data_out=0, busy=0, done=0. All counters are 0.
- rst in any state aborts the job on the next edge. A partially loaded or computed matrix is never output.
- Example with full-throughput input and start at cycle 0:
  - LOAD occupies cycles 1..2N².
  - COMPUTE occupies cycles 2N²+1..2N²+N³.
  - First out_valid is at cycle 2N²+N³+1. At N=3 that is cycle 46.
- With out_ready held high, UNLOAD takes N² cycles. done rises the cycle after the last beat.
- in_ready drops in the cycle after the final accepted input. No extra element is accepted.
- busy is high from the first LOAD cycle through the done cycle inclusive.

## Configuration
- MATMUL_ACC_EN
  - **Defined:** start with acc=1 begins COMPUTE with each accumulator seeded from the stored C[i][j] instead of 0, so C = C_prev + W·X. start with acc=0 behaves as the default. The sum wraps modulo 2^OW.
  - **Undefined:** the acc port is present but ignored. The accumulator always starts from 0, and C is not required to survive between jobs.

## Test plan
- Default parameters, W=identity, X=[1..9] row-major, out_ready=1:
  - outputs are 1,2,…,9;
  - first out_valid at cycle 46;
  - done at cycle 55.
- All W=X=15:
  - all nine outputs are 675;
  - no overflow at OW=10.
- Backpressure: X=[1..9], W=identity, out_ready=0 for 5 cycles on beat 3:
  - data_out holds 3 stable;
  - no beat is lost or duplicated.
- rst asserted mid-COMPUTE (cycle 30):
  - next cycle all outputs are 0 and busy=0;
  - a fresh job then gives correct results.
- start pulsed during LOAD and UNLOAD:
  - ignored;
  - element count and output count unchanged.
- MATMUL_ACC_EN defined, two jobs with all elements 15, second with acc=1:
  - second job outputs 1350 mod 1024 = 326 for all nine elements.
